// File: rtl/dm11a88_pkg.sv
// rtl/dm11a88_pkg.sv - shared types, constants and drive-word builder for the DM11A88 scan controller
// Contents: scan_state_e (controller states), WORD_W, BLANK_WORD, make_word(row, pixels)
package dm11a88_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD, BLANK} scan_state_e;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] BLANK_WORD = 16'hFF00;

  // Column sinks are active-low (0 = LED on); the row select is one-hot, active-high.
  function automatic logic [WORD_W-1:0] make_word(input logic [2:0] row, input logic [7:0] pixels);
    logic [7:0] sel;
    sel = 8'd1 << row;
    return {~pixels, sel};
  endfunction

endpackage

// File: rtl/dm11a88_shifter.sv
// rtl/dm11a88_shifter.sv - serial word shifter and latch strobe for the DM11A88 matrix
// Ports:
//   clk_50m, rst_n   system clock, asynchronous active-low reset
//   start            accept word while idle (sampled on the clock edge)
//   word[15:0]       drive word, shifted LSB first
//   done             1-cycle pulse during the last shift cycle (lat follows next cycle)
//   di, clk, lat     registered serial data, shift clock and latch strobe
import dm11a88_pkg::*;

module dm11a88_shifter #(
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              done,
  output logic              di,
  output logic              clk,
  output logic              lat
);

  localparam int HALF = BIT_CYCLES / 2;
  localparam int PW   = $clog2(BIT_CYCLES);

  logic              busy;
  logic [WORD_W-1:0] sreg;
  logic [3:0]        bit_idx;
  logic [PW-1:0]     phase;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      sreg    <= '0;
      bit_idx <= '0;
      phase   <= '0;
      done    <= 1'b0;
      di      <= 1'b0;
      clk     <= 1'b0;
      lat     <= 1'b0;
    end else begin
      done <= 1'b0;
      lat  <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          sreg    <= word;
          di      <= word[0];
          clk     <= 1'b0;
          bit_idx <= '0;
          phase   <= '0;
        end
      end else begin
        phase <= phase + 1'b1;
        if (phase == PW'(HALF - 1))
          clk <= 1'b1;
        // Registered early so the controller leaves SHIFT exactly as lat rises.
        if (phase == PW'(BIT_CYCLES - 2) && bit_idx == 4'd15)
          done <= 1'b1;
        if (phase == PW'(BIT_CYCLES - 1)) begin
          phase <= '0;
          clk   <= 1'b0;
          if (bit_idx == 4'd15) begin
            busy <= 1'b0;
            lat  <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            di      <= sreg[1];
            sreg    <= sreg >> 1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dm11a88_scan_ctrl.sv
// rtl/dm11a88_scan_ctrl.sv - double-buffered 8x8 row-scan controller for the DM11A88 LED matrix
// Parameters: BIT_CYCLES (clocks per serial bit), ROW_HOLD (clocks a row stays lit), ROWS (8)
// Ports:
//   clk_50m, rst_n            system clock, asynchronous active-low reset
//   enable                    scan enable; dropping it blanks the display after the current row
//   fb_we, fb_row, fb_data    back-buffer row write
//   fb_swap / swap_ack        swap request / 1-cycle pulse when applied at a row-0 load
//   frame_sync                1-cycle pulse at the start of the row-0 load
//   vcc, gnd                  constant module supply pins
//   di, clk, lat              serial interface to the matrix
//   bright[3:0]               only with DM11A88_DIM_EN: row is blanked early in HOLD
// Optional feature macro: DM11A88_DIM_EN
import dm11a88_pkg::*;

module dm11a88_scan_ctrl #(
  parameter int BIT_CYCLES = 4,
  parameter int ROW_HOLD   = 50000,
  parameter int ROWS       = 8
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fb_we,
  input  logic [2:0] fb_row,
  input  logic [7:0] fb_data,
  input  logic       fb_swap,
`ifdef DM11A88_DIM_EN
  input  logic [3:0] bright,
`endif
  output logic       swap_ack,
  output logic       frame_sync,
  output logic       vcc,
  output logic       gnd,
  output logic       di,
  output logic       clk,
  output logic       lat
);

  localparam int HW = $clog2(ROW_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ROW_HOLD - 1);

  scan_state_e       state;
  logic [2:0]        row;
  logic [HW-1:0]     hold_cnt;
  logic [1:0]        aux_ph;     // blank-word progress: 0 start, 1 shifting, 2 latching, 3 finished
  logic              front_sel;
  logic              pending;
  logic [7:0]        fb [0:1][0:7];
  logic              sh_start;
  logic              sh_done;
  logic [WORD_W-1:0] drive_word;
  logic              dim_fire;
  logic              hold_done;
  logic              load_next;
  logic              load_row0;

  assign vcc = 1'b1;
  assign gnd = 1'b0;

`ifdef DM11A88_DIM_EN
  logic [3:0] bright_q;
  int         dim_at;
  always_comb dim_at = ((int'(bright_q) + 1) * ROW_HOLD) / 16;
  assign dim_fire = (state == HOLD) && (aux_ph == 2'd0) && (bright_q != 4'd15) &&
                    (hold_cnt == HW'(dim_at));
`else
  assign dim_fire = 1'b0;
`endif

  // HOLD cannot end while an early blank word is still on the wire.
  assign hold_done = (state == HOLD) && (hold_cnt == HOLD_LAST) &&
                     (aux_ph != 2'd1) && (aux_ph != 2'd2);
  assign load_next = enable && ((state == IDLE) || hold_done);
  assign load_row0 = (state == IDLE) || (row == 3'(ROWS - 1));

  always_comb begin
    sh_start   = 1'b0;
    drive_word = BLANK_WORD;
    case (state)
      LOAD: begin
        sh_start   = 1'b1;
        drive_word = make_word(row, fb[front_sel][row]);
      end
      BLANK:   sh_start = (aux_ph == 2'd0);
      HOLD:    sh_start = dim_fire;
      default: sh_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      hold_cnt   <= '0;
      aux_ph     <= '0;
      front_sel  <= 1'b0;
      pending    <= 1'b0;
      swap_ack   <= 1'b0;
      frame_sync <= 1'b0;
`ifdef DM11A88_DIM_EN
      bright_q   <= 4'd15;
`endif
      for (int r = 0; r < 8; r++) begin
        fb[0][r] <= '0;
        fb[1][r] <= '0;
      end
    end else begin
      swap_ack   <= 1'b0;
      frame_sync <= 1'b0;
      if (fb_swap)
        pending <= 1'b1;
      if (fb_we)
        fb[~front_sel][fb_row] <= fb_data;
      // Swap on the edge entering a row-0 LOAD so the word captured in LOAD uses the new front.
      if (load_next && load_row0) begin
        frame_sync <= 1'b1;
        if (pending) begin
          front_sel <= ~front_sel;
          swap_ack  <= 1'b1;
          pending   <= 1'b0;
        end
      end
      case (state)
        IDLE: if (enable) state <= LOAD;
        LOAD: begin
          aux_ph <= 2'd0;
`ifdef DM11A88_DIM_EN
          bright_q <= bright;
`endif
          state <= SHIFT;
        end
        SHIFT: if (sh_done) state <= LATCH;
        LATCH: begin
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + 1'b1;
          if (sh_start)
            aux_ph <= 2'd1;
          else if (aux_ph == 2'd1 && sh_done)
            aux_ph <= 2'd2;
          else if (aux_ph == 2'd2)
            aux_ph <= 2'd3;
          if (hold_done) begin
            aux_ph <= 2'd0;
            if (enable) begin
              row   <= (row == 3'(ROWS - 1)) ? 3'd0 : row + 3'd1;
              state <= LOAD;
            end else begin
              // A restart after blanking begins a fresh frame.
              row   <= 3'd0;
              state <= BLANK;
            end
          end
        end
        BLANK: begin
          if (sh_start)
            aux_ph <= 2'd1;
          else if (aux_ph == 2'd1 && sh_done)
            aux_ph <= 2'd2;
          else if (aux_ph == 2'd2)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dm11a88_shifter #(.BIT_CYCLES(BIT_CYCLES)) u_shifter (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .start   (sh_start),
    .word    (drive_word),
    .done    (sh_done),
    .di      (di),
    .clk     (clk),
    .lat     (lat)
  );

endmodule

// File: tb/tb_dm11a88_scan_ctrl.sv
// tb/tb_dm11a88_scan_ctrl.sv - self-checking bench for dm11a88_scan_ctrl
module tb_dm11a88_scan_ctrl;

  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fb_we = 1'b0;
  logic [2:0] fb_row = '0;
  logic [7:0] fb_data = '0;
  logic       fb_swap = 1'b0;
`ifdef DM11A88_DIM_EN
  logic [3:0] bright = 4'd15;
`endif
  logic       swap_ack, frame_sync, vcc, gnd, di, clk, lat;

  dm11a88_scan_ctrl #(.BIT_CYCLES(4), .ROW_HOLD(160), .ROWS(8)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .enable     (enable),
    .fb_we      (fb_we),
    .fb_row     (fb_row),
    .fb_data    (fb_data),
    .fb_swap    (fb_swap),
`ifdef DM11A88_DIM_EN
    .bright     (bright),
`endif
    .swap_ack   (swap_ack),
    .frame_sync (frame_sync),
    .vcc        (vcc),
    .gnd        (gnd),
    .di         (di),
    .clk        (clk),
    .lat        (lat)
  );

  always #10 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Serial-protocol monitor: rebuilds each latched word from di at rising clk.
  logic [15:0] lat_words[$];
  int          lat_bits[$];
  int          fs_cyc[$];
  int          sa_cnt = 0;
  logic [15:0] sh = '0;
  int          bitcnt = 0, hi_len = 0, last_rise = 0;
  logic        p_clk = 1'b0, p_di = 1'b0, p_lat = 1'b0;
  int          viol_di = 0, viol_period = 0, viol_hi = 0, viol_lat = 0;

  always @(negedge clk_50m) begin
    if (!rst_n) begin
      sh = '0; bitcnt = 0; hi_len = 0;
      p_clk = 1'b0; p_di = 1'b0; p_lat = 1'b0;
    end else begin
      if (clk && !p_clk) begin
        sh = {di, sh[15:1]};
        bitcnt++;
        if (bitcnt >= 2 && (cyc - last_rise) != 4) viol_period++;
        last_rise = cyc;
      end
      if (clk && (di != p_di)) viol_di++;
      if (clk) hi_len++;
      else begin
        if (p_clk && hi_len != 2) viol_hi++;
        hi_len = 0;
      end
      if (lat) begin
        if (clk || p_lat) viol_lat++;
        lat_words.push_back(sh);
        lat_bits.push_back(bitcnt);
        bitcnt = 0;
      end
      if (frame_sync) fs_cyc.push_back(cyc);
      if (swap_ack) sa_cnt++;
      p_clk = clk; p_di = di; p_lat = lat;
    end
  end

  // sel: 0 = lat, 1 = frame_sync, 2 = swap_ack; returns on the negedge the signal is seen.
  task automatic wait_for(input int sel, input int budget, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk_50m);
      case (sel)
        0: hit = lat;
        1: hit = frame_sync;
        default: hit = swap_ack;
      endcase
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL timeout_%s actual=none required=pulse", name);
    end
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int n = 0;
    while (lat_words.size() < target && n < budget) begin
      @(negedge clk_50m);
      n++;
    end
    if (lat_words.size() < target) begin
      checks++; failures++;
      $display("FAIL timeout_%s actual=%0d required=%0d", name, lat_words.size(), target);
      $fatal(1, "stalled");
    end
  endtask

  typedef struct {
    logic [2:0]  row;
    logic [7:0]  data;
    logic [15:0] word;
  } vec_t;
  vec_t tbl[8];

  int e0, t0, sw0, widx, widx2, c5, nw, nfs, r0;

  initial begin
    tbl[0] = '{3'd0, 8'h00, 16'hFF01};
    tbl[1] = '{3'd1, 8'hFF, 16'h0002};
    tbl[2] = '{3'd2, 8'h0F, 16'hF004};
    tbl[3] = '{3'd3, 8'hA5, 16'h5A08};
    tbl[4] = '{3'd4, 8'h3C, 16'hC310};
    tbl[5] = '{3'd5, 8'h81, 16'h7E20};
    tbl[6] = '{3'd6, 8'h55, 16'hAA40};
    tbl[7] = '{3'd7, 8'h01, 16'hFE80};

    // Reset state
    repeat (3) @(negedge clk_50m);
    check("reset_outputs", {vcc, gnd, di, clk, lat, swap_ack, frame_sync}, 7'b1000000);
    rst_n = 1'b1;
    repeat (100) @(negedge clk_50m);
    check("idle_no_lat", lat_words.size(), 0);

    // First frame, front all zero
    enable = 1'b1; e0 = cyc;
    wait_for(1, 10, "first_sync");
    check("sync_delay", cyc - e0, 1);
    t0 = cyc;
    wait_for(0, 100, "first_lat");
    check("lat_latency", cyc - t0, 65);
    t0 = cyc;
    wait_for(0, 300, "second_lat");
    check("row_period", cyc - t0, 226);
    wait_words(9, 3000, "frame0");
    check("first_word", lat_words[0], 16'hFF01);
    check("first_bits", lat_bits[0], 16);
    check("row7_word", lat_words[7], 16'hFF80);
    check("wrap_word", lat_words[8], 16'hFF01);
    check("frame_period", fs_cyc[1] - fs_cyc[0], 1808);

    // Back-buffer table, double swap request
    wait_for(1, 2000, "pre_swap_sync");
    repeat (10) @(negedge clk_50m);
    for (int i = 0; i < 8; i++) begin
      fb_we = 1'b1; fb_row = tbl[i].row; fb_data = tbl[i].data;
      @(negedge clk_50m);
    end
    fb_we = 1'b0;
    fb_swap = 1'b1; sw0 = cyc;
    @(negedge clk_50m); fb_swap = 1'b0;
    @(negedge clk_50m); fb_swap = 1'b1;
    @(negedge clk_50m); fb_swap = 1'b0;
    wait_for(2, 2000, "swap_ack");
    check("swap_with_sync", frame_sync, 1'b1);
    check("swap_latency_ok", (cyc - sw0) <= 1809, 1'b1);
    widx = lat_words.size();
    fb_we = 1'b1; fb_row = 3'd0; fb_data = 8'hFF;   // lands in the new back buffer
    @(negedge clk_50m);
    fb_we = 1'b0;
    wait_words(widx + 8, 2500, "swapped_frame");
    for (int i = 0; i < 8; i++)
      check($sformatf("tbl_row%0d", i), lat_words[widx + i], tbl[i].word);
    wait_words(widx + 16, 2500, "frame_after");
    check("single_swap", sa_cnt, 1);
    check("no_swap_back", lat_words[widx + 11], 16'h5A08);

    // Second swap exposes the old front plus the ack-cycle write
    wait_for(1, 2000, "pre_swap2_sync");
    repeat (10) @(negedge clk_50m);
    fb_swap = 1'b1;
    @(negedge clk_50m); fb_swap = 1'b0;
    wait_for(2, 2000, "swap_ack2");
    widx2 = lat_words.size();
    wait_words(widx2 + 8, 2500, "swap2_frame");
    check("ack_write_row0", lat_words[widx2], 16'h0001);
    check("old_front_row3", lat_words[widx2 + 3], 16'hFF08);
    check("swap_count", sa_cnt, 2);

    // Drop enable during SHIFT of row 5
    wait_for(1, 2000, "drop_sync");
    for (int i = 0; i < 5; i++) wait_for(0, 300, "drop_rows");
    repeat (190) @(negedge clk_50m);
    enable = 1'b0;
    wait_for(0, 300, "row5_lat");
    c5 = cyc;
    wait_for(0, 400, "blank_lat");
    check("blank_gap", cyc - c5, 226);
    @(negedge clk_50m);
    nw = lat_words.size();
    check("row5_word", lat_words[nw - 2], 16'hFF20);
    check("blank_word", lat_words[nw - 1], 16'hFF00);
    nfs = fs_cyc.size();
    repeat (600) @(negedge clk_50m);
    check("idle_after_blank", {lat_words.size() - nw, fs_cyc.size() - nfs}, 0);

    // Asynchronous reset in the middle of SHIFT
    enable = 1'b1;
    wait_for(1, 10, "pre_reset_sync");
    repeat (32) @(negedge clk_50m);
    check("pre_reset_clk_high", clk, 1'b1);
    #5 rst_n = 1'b0;
    #1 check("async_reset_outs", {di, clk, lat, swap_ack, frame_sync}, 5'b00000);
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1; r0 = cyc;
    wait_for(1, 10, "restart_sync");
    check("restart_sync_delay", cyc - r0, 1);
    t0 = cyc;
    wait_for(0, 100, "restart_lat");
    check("restart_lat_latency", cyc - t0, 65);
    @(negedge clk_50m);
    check("restart_word", lat_words[lat_words.size() - 1], 16'hFF01);
    check("restart_bits", lat_bits[lat_bits.size() - 1], 16);

`ifdef DM11A88_DIM_EN
    bright = 4'd3;
    wait_for(1, 2000, "dim_sync");
    wait_for(0, 100, "dim_row0_lat");
    t0 = cyc;
    wait_for(0, 300, "dim_blank_lat");
    check("dim_blank_at", cyc - t0, 106);
    @(negedge clk_50m);
    check("dim_blank_word", lat_words[lat_words.size() - 1], 16'hFF00);
    wait_for(0, 300, "dim_row1_lat");
    check("dim_row_gap", cyc - t0, 226);
    t0 = cyc;
    bright = 4'd15;
    wait_for(0, 300, "dim_row1_blank");
    check("dim_row1_blank_at", cyc - t0, 106);
    t0 = cyc;
    wait_for(0, 300, "row2_lat");
    check("row2_gap", cyc - t0, 120);
    t0 = cyc;
    wait_for(0, 300, "row3_lat");
    check("bright15_no_blank", cyc - t0, 226);
`endif

    check("di_stable_clk_high", viol_di, 0);
    check("clk_period_4", viol_period, 0);
    check("clk_high_2", viol_hi, 0);
    check("lat_1cyc_clk_low", viol_lat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
